// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Show-ahead byte FIFO sitting directly upstream of the UART
//                transmitter. The bus side enqueues one byte per cycle with a
//                write strobe. The transmitter side sees the head byte on
//                o_tx_data/o_tx_data_valid and pops it with i_tx_data_ack.
//
//  Parameters  : DEPTH  entry count, power of two, 2..256
//                AW     pointer width, derived as $clog2(DEPTH)
//
//  Ports       : clk              system clock
//                rst_n            asynchronous active-low reset
//                i_wr_data[7:0]   byte to enqueue
//                i_wr_en          enqueue strobe
//                i_flush          synchronous clear of all entries
//                o_full           no free entry
//                o_empty          no entry held
//                o_level[AW:0]    entries held, 0..DEPTH
//                o_ovf            sticky overflow flag
//                i_ovf_clr        clears o_ovf
//                o_tx_data[7:0]   head byte
//                o_tx_data_valid  head byte present
//                i_tx_data_ack    transmitter captured head byte
//
//  Build option: UART_TX_FIFO_OVF_EN
//                defined   : o_ovf is a sticky flag set by a write while full
//                undefined : o_ovf is tied low and i_ovf_clr is ignored
//
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    i_wr_data,
    input  logic          i_wr_en,
    input  logic          i_flush,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_level,
    output logic          o_ovf,
    input  logic          i_ovf_clr,
    output logic [7:0]    o_tx_data,
    output logic          o_tx_data_valid,
    input  logic          i_tx_data_ack
);

    localparam logic [AW:0] c_full_level = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_level;
    logic          r_ack_mask;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    // Fullness is judged on the pre-edge level, so a push at full is dropped
    // even when a pop frees an entry at the same edge.
    assign w_full  = (r_level == c_full_level);
    assign w_empty = (r_level == '0);

    // Flush wins over both push and pop. The ack mask swallows the ack that
    // follows a capture made at the flush edge, so it cannot pop new data.
    assign w_push  = i_wr_en && !w_full && !i_flush;
    assign w_pop   = i_tx_data_ack && !w_empty && !r_ack_mask && !i_flush;

    // Storage array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_level    <= '0;
            r_ack_mask <= 1'b0;
        end else begin
            r_ack_mask <= i_flush;
            if (i_flush) begin
                r_wp    <= '0;
                r_rp    <= '0;
                r_level <= '0;
            end else begin
                if (w_push) begin
                    r_wp <= r_wp + 1'b1;
                end
                if (w_pop) begin
                    r_rp <= r_rp + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_level <= r_level + 1'b1;
                end else if (!w_push && w_pop) begin
                    r_level <= r_level - 1'b1;
                end
            end
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic r_ovf;

    // Set has priority over clear so an overflow in the clear cycle is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (i_wr_en && w_full) begin
            r_ovf <= 1'b1;
        end else if (i_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign o_ovf = r_ovf;
`else
    logic w_unused_ovf_clr;

    assign w_unused_ovf_clr = i_ovf_clr;
    assign o_ovf            = 1'b0;
`endif

    assign o_full          = w_full;
    assign o_empty         = w_empty;
    assign o_level         = r_level;
    assign o_tx_data       = r_mem[r_rp];
    assign o_tx_data_valid = !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Directed bench for uart_tx_fifo. Accepted bytes are queued in
//                a scoreboard when issued; a monitor pops and compares each
//                byte the FIFO hands to the transmitter on an applied ack.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
`ifdef UART_TX_FIFO_OVF_EN
    localparam logic c_exp_ovf = 1'b1;
`else
    localparam logic c_exp_ovf = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          flush;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          ovf;
    logic          ovf_clr;
    logic [7:0]    tx_data;
    logic          tx_data_valid;
    logic          tx_ack;

    int            total;
    int            bad;
    int            m_level;
    bit            m_mask;
    logic [7:0]    exp_q[$];
    logic [7:0]    exp_b;
    int            nvalid;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_wr_data       (wr_data),
        .i_wr_en         (wr_en),
        .i_flush         (flush),
        .o_full          (full),
        .o_empty         (empty),
        .o_level         (level),
        .o_ovf           (ovf),
        .i_ovf_clr       (ovf_clr),
        .o_tx_data       (tx_data),
        .o_tx_data_valid (tx_data_valid),
        .i_tx_data_ack   (tx_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: inputs change just after the rising edge, so at the falling
    // edge both the ack and the presented head byte are stable for the
    // upcoming edge. A pop happens there only when not masked or flushed.
    always @(negedge clk) begin
        if (rst_n && tx_ack && tx_data_valid && !m_mask && !flush) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_pop: got byte %02h, expected none", tx_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (tx_data !== exp_b) begin
                    bad++;
                    $display("FAIL sb_data: got %02h, expected %02h", tx_data, exp_b);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One clock cycle of stimulus; the scoreboard records bytes the FIFO
    // should accept, judged on the pre-edge reference level.
    task automatic cyc(input logic we, input logic [7:0] d, input logic ack, input logic fl);
        bit acc;
        bit pp;
        wr_en   = we;
        wr_data = d;
        tx_ack  = ack;
        flush   = fl;
        @(posedge clk);
        if (fl) begin
            m_level = 0;
            exp_q.delete();
        end else begin
            acc = we && (m_level != DEPTH);
            pp  = ack && (m_level != 0) && !m_mask;
            if (acc) exp_q.push_back(d);
            m_level = m_level + int'(acc) - int'(pp);
        end
        m_mask = fl;
        #1;
        wr_en   = 1'b0;
        flush   = 1'b0;
        tx_ack  = 1'b0;
        ovf_clr = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        m_level = 0;
        m_mask  = 1'b0;
        rst_n   = 1'b0;
        wr_data = 8'h00;
        wr_en   = 1'b0;
        flush   = 1'b0;
        ovf_clr = 1'b0;
        tx_ack  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full",  full,  0);
        chk("rst_level", level, 0);
        chk("rst_valid", tx_data_valid, 0);
        chk("rst_ovf",   ovf,   0);
        rst_n = 1'b1;
        cyc(0, 8'h00, 0, 0);

        // Basic burst
        cyc(1, 8'h41, 0, 0);
        cyc(1, 8'h42, 0, 0);
        cyc(1, 8'h43, 0, 0);
        chk("burst_level", level, 3);
        chk("burst_head",  tx_data, 8'h41);
        chk("burst_valid", tx_data_valid, 1);
        cyc(0, 8'h00, 1, 0);
        chk("ack1_head", tx_data, 8'h42);
        cyc(0, 8'h00, 1, 0);
        chk("ack2_head", tx_data, 8'h43);
        cyc(0, 8'h00, 1, 0);
        chk("ack3_empty", empty, 1);

        // Fill, overflow, push-at-full with pop, drain
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 0, 0);
        chk("fill_full",  full, 1);
        chk("fill_level", level, DEPTH);
        cyc(1, 8'hFF, 0, 0);
        chk("ovf_full",  full, 1);
        chk("ovf_level", level, DEPTH);
        chk("ovf_set",   ovf, c_exp_ovf);
        ovf_clr = 1'b1;
        cyc(0, 8'h00, 0, 0);
        chk("ovf_clr", ovf, 0);
        cyc(1, 8'hEE, 1, 0);
        chk("fullpop_level", level, DEPTH - 1);
        chk("fullpop_full",  full, 0);
        chk("fullpop_ovf",   ovf, c_exp_ovf);
        repeat (DEPTH - 1) cyc(0, 8'h00, 1, 0);
        chk("drain_empty", empty, 1);
        chk("drain_level", level, 0);

        // Pointer wrap with simultaneous push and pop at level 1
        cyc(1, 8'h80, 0, 0);
        for (int i = 0; i < 40; i++) begin
            cyc(1, 8'(8'h90 + i), 1, 0);
            if (i == 20) chk("wrap_mid_level", level, 1);
        end
        chk("wrap_level", level, 1);
        chk("wrap_head",  tx_data, 8'(8'h90 + 39));
        cyc(0, 8'h00, 1, 0);
        chk("wrap_empty", empty, 1);

        // Acks while empty are ignored
        repeat (3) cyc(0, 8'h00, 1, 0);
        chk("eack_level", level, 0);
        chk("eack_empty", empty, 1);
        cyc(1, 8'h55, 0, 0);
        chk("eack_head",  tx_data, 8'h55);
        chk("eack_lvl1",  level, 1);
        cyc(0, 8'h00, 1, 0);

        // Flush, then ack alongside a new push
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h10 + i), 0, 0);
        chk("pre_flush_level", level, 5);
        cyc(0, 8'h00, 0, 1);
        chk("flush_level", level, 0);
        chk("flush_empty", empty, 1);
        cyc(1, 8'h77, 1, 0);
        chk("postflush_level", level, 1);
        chk("postflush_head",  tx_data, 8'h77);
        cyc(0, 8'h00, 1, 0);
        chk("postflush_empty", empty, 1);

        // Transmitter (divisor 4, 10-bit frame = 40 cycles) with reset mid-frame
        cyc(1, 8'h55, 0, 0);
        cyc(1, 8'hA3, 0, 0);
        cyc(0, 8'h00, 0, 0);               // capture 0x55
        cyc(0, 8'h00, 1, 0);               // ack 0x55
        chk("tx_head2", tx_data, 8'hA3);
        repeat (38) cyc(0, 8'h00, 0, 0);   // rest of first frame
        cyc(0, 8'h00, 0, 0);               // capture 0xA3
        cyc(0, 8'h00, 1, 0);               // ack 0xA3
        chk("tx_empty2", empty, 1);
        repeat (4) cyc(0, 8'h00, 0, 0);
        cyc(1, 8'h3C, 0, 0);
        chk("tx_queued3", level, 1);
        repeat (10) cyc(0, 8'h00, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_level", level, 0);
        chk("arst_empty", empty, 1);
        chk("arst_valid", tx_data_valid, 0);
        exp_q.delete();
        m_level = 0;
        m_mask  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        nvalid = 0;
        repeat (50) begin
            cyc(0, 8'h00, 0, 0);
            if (tx_data_valid) nvalid++;
        end
        chk("no_third_frame", nvalid, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
